// File: rtl/fft_frame_collector.sv
// fft_frame_collector: serial sample stream to 8-wide ping-pong frame for the 8-point FFT
//   clk, rst_n           : clock, async active-low reset
//   restart              : sync, drops the partially filled frame
//   s_valid/s_data/s_ready : sample input handshake
//   x0..x7               : held frame, oldest sample in x0
//   frame_valid/frame_ack: frame output handshake
//   frame_count          : frames presented, modulo 2^CNT_W
module fft_frame_collector #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [DATA_W-1:0] x0,
  output logic [DATA_W-1:0] x1,
  output logic [DATA_W-1:0] x2,
  output logic [DATA_W-1:0] x3,
  output logic [DATA_W-1:0] x4,
  output logic [DATA_W-1:0] x5,
  output logic [DATA_W-1:0] x6,
  output logic [DATA_W-1:0] x7,
  output logic              frame_valid,
  input  logic              frame_ack,
  output logic [CNT_W-1:0]  frame_count
);
  typedef enum logic {FILL, HOLD} state_e;
  state_e            state_q;
  logic [2:0]        wr_idx_q;
  logic [DATA_W-1:0] fill_q [8];
  logic [DATA_W-1:0] x_q [8];
  logic              frame_valid_q;
  logic [CNT_W-1:0]  frame_count_q;
  logic              out_free;
  logic              consume;
  assign out_free = !frame_valid_q | frame_ack;
  assign consume  = frame_valid_q & frame_ack;
  assign s_ready  = (state_q == FILL);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FILL;
      wr_idx_q      <= '0;
      frame_valid_q <= 1'b0;
      frame_count_q <= '0;
      for (int i = 0; i < 8; i++) begin
        fill_q[i] <= '0;
        x_q[i]    <= '0;
      end
    end else begin
      // a consumed frame drops valid unless a new frame loads on this same edge
      if (consume) frame_valid_q <= 1'b0;
      if (restart) begin
        wr_idx_q <= '0;
        state_q  <= FILL;
      end else if (state_q == FILL) begin
        if (s_valid) begin
          fill_q[wr_idx_q] <= s_data;
          if (wr_idx_q == 3'd7 && out_free) begin
            // last sample bypasses the fill bank straight into x7
            for (int i = 0; i < 7; i++) x_q[i] <= fill_q[i];
            x_q[7]        <= s_data;
            frame_valid_q <= 1'b1;
            frame_count_q <= frame_count_q + CNT_W'(1);
            wr_idx_q      <= '0;
          end else if (wr_idx_q == 3'd7) begin
            state_q <= HOLD;
          end else begin
            wr_idx_q <= wr_idx_q + 3'd1;
          end
        end
      end else if (out_free) begin
        for (int i = 0; i < 8; i++) x_q[i] <= fill_q[i];
        frame_valid_q <= 1'b1;
        frame_count_q <= frame_count_q + CNT_W'(1);
        wr_idx_q      <= '0;
        state_q       <= FILL;
      end
    end
  end
  assign x0          = x_q[0];
  assign x1          = x_q[1];
  assign x2          = x_q[2];
  assign x3          = x_q[3];
  assign x4          = x_q[4];
  assign x5          = x_q[5];
  assign x6          = x_q[6];
  assign x7          = x_q[7];
  assign frame_valid = frame_valid_q;
  assign frame_count = frame_count_q;
endmodule

// File: tb/tb_fft_frame_collector.sv
// tb_fft_frame_collector: directed and random checks against a queue-based frame model
module tb_fft_frame_collector;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        frame_ack = 1'b0;
  logic        s_ready;
  logic [31:0] x0, x1, x2, x3, x4, x5, x6, x7;
  logic        frame_valid;
  logic [7:0]  frame_count;
  int          passed = 0;
  int          total = 0;
  int          failed = 0;
  logic [31:0] part [$];
  logic        held;
  logic [31:0] m_x [8];
  logic        m_fv;
  logic [7:0]  m_cnt;
  logic [31:0] xo [8];

  fft_frame_collector #(.DATA_W(32), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6), .x7(x7),
    .frame_valid(frame_valid), .frame_ack(frame_ack), .frame_count(frame_count)
  );

  always #5 clk = ~clk;
  assign xo = '{x0, x1, x2, x3, x4, x5, x6, x7};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    part.delete();
    held = 1'b0;
    m_fv = 1'b0;
    m_cnt = '0;
    for (int i = 0; i < 8; i++) m_x[i] = '0;
  endtask

  task automatic m_load();
    for (int i = 0; i < 8; i++) m_x[i] = part[i];
    part.delete();
    m_fv = 1'b1;
    m_cnt++;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(m_fv));
    chk({tag, ".frame_count"}, 32'(frame_count), 32'(m_cnt));
    chk({tag, ".s_ready"}, 32'(s_ready), 32'(!held));
    for (int i = 0; i < 8; i++) chk($sformatf("%s.x%0d", tag, i), xo[i], m_x[i]);
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic ack, input logic rs);
    logic free;
    s_valid = v;
    s_data = d;
    frame_ack = ack;
    restart = rs;
    @(posedge clk);
    free = !m_fv || ack;
    if (m_fv && ack) m_fv = 1'b0;
    if (rs) begin
      part.delete();
      held = 1'b0;
    end else if (!held) begin
      if (v) begin
        part.push_back(d);
        if (part.size() == 8) begin
          if (free) m_load();
          else held = 1'b1;
        end
      end
    end else if (free) begin
      m_load();
      held = 1'b0;
    end
    #1;
    check_all("step");
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    frame_ack = 1'b0;
    restart = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    m_reset();
    check_all("reset");
    #3 rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] tp1 [8];
    tp1 = '{1, 2, 3, 4, 4, 3, 2, 1};
    m_reset();
    #12;
    check_all("por");
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, tp1[i], 1'b0, 1'b0);
    chk("tp1.fv", 32'(frame_valid), 32'd1);
    chk("tp1.x7", x7, 32'd1);
    chk("tp1.cnt", 32'(frame_count), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 1; i <= 24; i++) step(1'b1, 32'(i), 1'b1, 1'b0);
    chk("tp2.cnt", 32'(frame_count), 32'd4);
    chk("tp2.x0", x0, 32'd17);
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 1; i <= 16; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
    chk("tp3.hold_ready", 32'(s_ready), 32'd0);
    chk("tp3.hold_x0", x0, 32'd1);
    step(1'b1, 32'hDEAD, 1'b1, 1'b0);
    chk("tp3.x0", x0, 32'd9);
    chk("tp3.x7", x7, 32'd16);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("tp3.ready_back", 32'(s_ready), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 5; i <= 7; i++) step(1'b1, 32'(-i), 1'b0, 1'b0);
    step(1'b1, 32'(-100), 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) step(1'b1, 32'(-i), 1'b0, 1'b0);
    chk("tp4.x0", x0, 32'hFFFFFFFF);
    chk("tp4.x7", x7, 32'hFFFFFFF8);
    for (int i = 0; i < 5; i++) step(1'b1, 32'(100 + i), 1'b0, 1'b0);
    do_reset();
    chk("tp5.x0", x0, 32'd0);
    for (int i = 1; i <= 8; i++) step(1'b1, 32'(40 + i), 1'b0, 1'b0);
    chk("tp5.x0_clean", x0, 32'd41);
    do_reset();
    for (int i = 0; i < 2048; i++) step(1'b1, $urandom, 1'b1, 1'b0);
    chk("tp6.wrap", 32'(frame_count), 32'd0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 31) == 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
